dm_access_unit: RTL and testbench

- Memory-stage initiator for the word-organised data memory (1024 x 32, word index = address[11:2], combinational read, posedge write, write-enable and read-enable strobes, PC passed through for the store trace).
- Accepts one load or store request at a time from the pipeline MEM stage.
- Checks alignment and range, and performs sub-word stores as read-modify-write, because the memory writes whole words only.
- Returns sign- or zero-extended load data with a registered response handshake.

---
 rtl/dm_access_unit_pkg.sv | 50 +++++
 rtl/dm_access_unit_lane.sv | 46 ++++
 rtl/dm_access_unit.sv | 147 ++++++++++++++
 tb/tb_dm_access_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: op codes, FSM states and sizing.
// Pure declarations and small helpers; no logic state lives here.
// Imported by dm_access_unit and dm_lane_unit.
package dm_access_unit_pkg;

  localparam int unsigned DM_WORDS_DEF = 1024;
  localparam int unsigned DM_AW_DEF    = 10;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RMWRD = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Word ops need a 4-byte aligned address, halfword ops a 2-byte aligned one.
  function automatic logic is_misaligned(input op_e op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW:          bad = (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH:  bad = lo[0];
      default:               bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Stores narrower than a word have to read the old word first.
  function automatic logic is_subword_store(input op_e op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_load(input op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/dm_access_unit_lane.sv
// Byte-lane select, load extension and sub-word store merge for the access unit.
// Purely combinational, zero latency.
// No handshake; the enclosing FSM decides when the outputs are used.
module dm_lane_unit
  import dm_access_unit_pkg::*;
(
  input  op_e         op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword out of the little-endian word.
  always_comb begin
    byte_sel = rword_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  // Extend the selected lane to a full word for the load response.
  always_comb begin
    load_o = rword_i;
    case (op_i)
      OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_o = {16'h0000, half_sel};
      OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_o = {24'h000000, byte_sel};
      default: load_o = rword_i;
    endcase
  end

  // Replace the target lane of the old word with the new store data.
  always_comb begin
    merge_o = rword_i;
    case (op_i)
      OP_SB:   merge_o[{lane_i, 3'b000} +: 8]        = wdata_i[7:0];
      OP_SH:   merge_o[{lane_i[1], 4'b0000} +: 16]   = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage initiator for the word-organised data memory: checks, loads, RMW sub-word stores.
// Response after 1 cycle (error), 2 (load/SW) or 3 (SH/SB) from acceptance.
// One request in flight; req_ready is low from acceptance until the cycle after the response.
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int unsigned DM_WORDS = DM_WORDS_DEF,
  parameter int unsigned AW       = DM_AW_DEF
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic        dm_re,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  op_e         req_op_e;
  logic        req_misal;
  logic        req_oor;
  logic        req_bad;
  logic        accept;
  logic [31:0] lane_load;
  logic [31:0] lane_merge;

  // Classify the incoming request; out of range means any byte beyond the last word.
  always_comb begin
    req_op_e  = op_e'(req_op);
    req_misal = is_misaligned(req_op_e, req_addr[1:0]);
    req_oor   = (|req_addr[31:AW+2]) ||
                ({1'b0, req_addr[AW+1:2]} >= (AW+1)'(DM_WORDS));
    req_bad   = req_misal || req_oor;
    accept    = req_valid && (state_q == IDLE);
  end

  dm_lane_unit u_lane (
    .op_i    (op_q),
    .lane_i  (addr_q[1:0]),
    .rword_i (dm_rdata),
    .wdata_i (wdata_q),
    .load_o  (lane_load),
    .merge_o (lane_merge)
  );

  // Next-state and request-latch update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = req_op_e;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          pc_d    = req_pc;
          rdata_d = 32'h0;
          err_d   = req_bad;
          if (req_bad) begin
            state_d = RESP;
          end else if (is_load(req_op_e)) begin
            state_d = LOAD;
          end else if (is_subword_store(req_op_e)) begin
            state_d = RMWRD;
          end else begin
            state_d = WRITE;
          end
        end
      end
      LOAD: begin
        rdata_d = lane_load;
        state_d = RESP;
      end
      RMWRD: begin
        // The merged word replaces the raw store data so WRITE drives it unchanged.
        wdata_d = lane_merge;
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= OP_LW;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      pc_q    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from the registered state; memory bus is quiet while idle.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
    resp_err   = (state_q == RESP) ? err_q : 1'b0;
    dm_re      = (state_q == LOAD) || (state_q == RMWRD);
    dm_we      = (state_q == WRITE) && !Reset;
    dm_addr    = 32'h0;
    dm_wdata   = 32'h0;
    dm_pc      = 32'h0;
    if (state_q != IDLE) begin
      dm_addr  = addr_q;
      dm_wdata = wdata_q;
      dm_pc    = pc_q;
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Self-checking bench for dm_access_unit: directed cases plus random traffic
// checked against an arithmetic reference of the memory contents.
// Hosts a behavioural 1024-word data memory driven by the DUT's bus.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic        dm_re;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dm_access_unit dut (
    .clk        (clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_we      (dm_we),
    .dm_re      (dm_re),
    .dm_pc      (dm_pc),
    .dm_rdata   (dm_rdata)
  );

  assign dm_rdata = mem[dm_addr[11:2]];

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[11:2]] <= dm_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  // Reference: what a request should do, derived from byte arithmetic on ref_mem.
  task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] rdata, output logic wr,
                       output logic [31:0] wword, output int lat,
                       output logic [7:0] re_m, output logic [7:0] we_m);
    int unsigned idx, lane, sh;
    logic [31:0] old, b, h, mask;
    logic mis;
    idx  = addr / 4;
    lane = addr % 4;
    mis  = ((op == 0 || op == 5) && lane != 0) || ((op == 1 || op == 2 || op == 6) && (lane % 2) != 0);
    err  = mis || (addr >= 32'd4096);
    rdata = 0; wr = 0; wword = 0; re_m = 0; we_m = 0;
    if (err) begin
      lat = 1;
      return;
    end
    old = ref_mem[idx];
    sh  = 8 * lane;
    b   = (old >> sh) & 32'hFF;
    h   = (old >> sh) & 32'hFFFF;
    case (op)
      0: rdata = old;
      1: rdata = (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      2: rdata = h;
      3: rdata = (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      4: rdata = b;
      default: rdata = 0;
    endcase
    if (op <= 4) begin
      lat = 2; re_m = 8'b0000_0010;
    end else if (op == 5) begin
      lat = 2; we_m = 8'b0000_0010; wr = 1; wword = wd;
    end else begin
      lat = 3; re_m = 8'b0000_0010; we_m = 8'b0000_0100; wr = 1;
      mask  = (op == 6) ? 32'hFFFF : 32'hFF;
      wword = (old & ~(mask << sh)) | ((wd & mask) << sh);
    end
    if (wr) ref_mem[idx] = wword;
  endtask

  task automatic run_req(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] pc);
    logic e, wr, got, ge, both, abad;
    logic [31:0] er, ew, gr, gwd, gpc;
    logic [7:0] erm, ewm, rem, wem;
    int lat, gl;
    model(op, addr, wd, e, er, wr, ew, lat, erm, ewm);
    @(negedge clk);
    chk("ready_before", req_ready, 1);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd; req_pc = pc;
    @(posedge clk);
    #1;
    req_valid = 0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom; req_pc = $urandom;
    rem = 0; wem = 0; got = 0; both = 0; abad = 0; gl = 0; gr = 0; ge = 0; gwd = 0; gpc = 0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      if (dm_re) rem[c] = 1'b1;
      if (dm_we) wem[c] = 1'b1;
      if (dm_re && dm_we) both = 1;
      if ((dm_re || dm_we) && dm_addr != addr) abad = 1;
      if (dm_we) begin gwd = dm_wdata; gpc = dm_pc; end
      if (resp_valid) begin got = 1; gl = c; gr = resp_rdata; ge = resp_err; end
    end
    chk("resp_seen", got, 1);
    chk("latency", gl, lat);
    chk("rdata", gr, er);
    chk("err", ge, e);
    chk("re_cycles", rem, erm);
    chk("we_cycles", wem, ewm);
    chk("re_we_excl", both, 0);
    chk("bus_addr", abad, 0);
    if (wr) begin
      chk("wdata", gwd, ew);
      chk("dm_pc", gpc, pc);
    end
    @(negedge clk);
    chk("resp_pulse", resp_valid, 0);
    chk("ready_after", req_ready, 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_rv"}, resp_valid, 0);
    chk({tag, "_rd"}, resp_rdata, 0);
    chk({tag, "_re"}, resp_err, 0);
    chk({tag, "_addr"}, dm_addr, 0);
    chk({tag, "_wd"}, dm_wdata, 0);
    chk({tag, "_pc"}, dm_pc, 0);
    chk({tag, "_we"}, dm_we, 0);
    chk({tag, "_ren"}, dm_re, 0);
  endtask

  initial begin
    logic [2:0] op;
    logic [31:0] addr, old;
    int r, diff;
    for (int i = 0; i < 1024; i++) set_word(i, $urandom);
    Reset = 1; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; req_pc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    Reset = 0;

    // Directed scenarios.
    set_word(4, 32'h8899AABB);
    run_req(3'd0, 32'h10, 32'h0, 32'h100);
    run_req(3'd3, 32'h13, 32'h0, 32'h104);
    run_req(3'd4, 32'h13, 32'h0, 32'h108);
    set_word(8, 32'h11223344);
    run_req(3'd7, 32'h21, 32'h000000CC, 32'h10C);
    run_req(3'd0, 32'h20, 32'h0, 32'h110);
    set_word(1, 32'h0);
    run_req(3'd6, 32'h06, 32'h0000BEEF, 32'h114);
    run_req(3'd0, 32'h04, 32'h0, 32'h118);
    run_req(3'd1, 32'h05, 32'h0, 32'h11C);
    run_req(3'd5, 32'h1000, 32'h12345678, 32'h120);
    run_req(3'd5, 32'hFFC, 32'hDEADBEEF, 32'hCAFE0124);
    chk("word1023", mem[1023], 32'hDEADBEEF);

    // Reset while the SB is in its read cycle: no write, no response.
    set_word(8, 32'h11223344);
    @(negedge clk);
    req_valid = 1; req_op = 3'd7; req_addr = 32'h21; req_wdata = 32'hAA; req_pc = 32'h200;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("rst_rmw_re", dm_re, 1);
    Reset = 1;
    #1 chk("rst_rmw_we", dm_we, 0);
    @(posedge clk);
    #1 Reset = 0;
    @(negedge clk);
    chk_idle_outputs("rst_rmw");
    repeat (2) begin
      @(negedge clk);
      chk("rst_rmw_norsp", resp_valid, 0);
    end
    chk("rst_rmw_mem", mem[8], 32'h11223344);

    // Reset during the write cycle of an SW must suppress the write itself.
    old = mem[9];
    @(negedge clk);
    req_valid = 1; req_op = 3'd5; req_addr = 32'h24; req_wdata = ~old; req_pc = 32'h204;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("rst_wr_we_pre", dm_we, 1);
    Reset = 1;
    #1 chk("rst_wr_we_gated", dm_we, 0);
    @(posedge clk);
    #1 Reset = 0;
    @(negedge clk);
    chk("rst_wr_mem", mem[9], old);
    chk("rst_wr_ready", req_ready, 1);

    // Random traffic over a small window so stores and loads interact.
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 19);
      if (r == 0) begin
        addr = $urandom;
      end else if (r == 1) begin
        addr = 32'hFFC + 32'($urandom_range(0, 7));
      end else begin
        addr = 32'($urandom_range(0, 31)) << 2;
        if ($urandom_range(0, 3) == 0) addr += 32'($urandom_range(0, 3));
        else if (op == 1 || op == 2 || op == 6) addr += 32'($urandom_range(0, 1)) << 1;
        else if (op == 3 || op == 4 || op == 7) addr += 32'($urandom_range(0, 3));
      end
      run_req(op, addr, $urandom, $urandom);
    end

    diff = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("mem_final", diff, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
